// File: rtl/mem_port_arbiter_pkg.sv
// Shared codes for the unified memory-port arbiter: FSM states, owner codes,
// timeout fill data and the IF/DM tie-break rule.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    // A lone request wins outright; under contention the side that did not win last time goes.
    function automatic arb_owner_e pick_owner(input logic if_req, input logic dm_req,
                                              input logic last_dm);
        arb_owner_e o;
        if (if_req && dm_req) begin
            if (last_dm) o = OWN_IF;
            else         o = OWN_DM;
        end else if (if_req) begin
            o = OWN_IF;
        end else begin
            o = OWN_DM;
        end
        return o;
    endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// BUSY-state watchdog: counts stalled cycles and flags expiry on the TIMEOUT-th one.
module mem_arb_wdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (en)   cnt <= cnt + 1'b1;
    end

    // Fires during the last allowed stalled cycle so the FSM leaves BUSY on that edge.
    assign expire = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and lw/sw data accesses.
// Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          err
);

    arb_state_e    state;
    arb_owner_e    owner;
    arb_owner_e    grant;
    logic          last_dm;
    logic [AW-3:0] cap_addr;
    logic          cap_we;
    logic [DW-1:0] cap_wdata;
    logic          tmo_expire;
    logic [DW-1:0] rd_data;

    // Word-aligned port: byte-offset bits never reach memory.
    logic unused_lsb;
    assign unused_lsb = ^{if_addr[1:0], dm_addr[1:0]};

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != BUSY),
        .en     ((state == BUSY) && !mem_ready),
        .expire (tmo_expire)
    );
`else
    localparam int unsigned unused_timeout = TIMEOUT;
    assign tmo_expire = 1'b0;
`endif

    always_comb grant = pick_owner(if_req, dm_req, last_dm);

    // A stalled access that times out returns a recognisable poison word.
    assign rd_data = mem_ready ? mem_rdata : DW'(TIMEOUT_DATA);

    assign mem_addr  = {cap_addr, 2'b00};
    assign mem_we    = cap_we;
    assign mem_wdata = cap_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            last_dm   <= 1'b0;
            cap_addr  <= '0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
            mem_req   <= 1'b0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            err       <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        owner   <= grant;
                        mem_req <= 1'b1;
                        state   <= BUSY;
                        if (grant == OWN_IF) begin
                            cap_addr <= if_addr[AW-1:2];
                            cap_we   <= 1'b0;
                        end else begin
                            cap_addr  <= dm_addr[AW-1:2];
                            cap_we    <= dm_we;
                            cap_wdata <= dm_wdata;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready || tmo_expire) begin
                        mem_req <= 1'b0;
                        err     <= !mem_ready;
                        state   <= DONE;
                        if (owner == OWN_IF) begin
                            if_ack   <= 1'b1;
                            if_rdata <= rd_data;
                        end else begin
                            dm_ack <= 1'b1;
                            if (!cap_we) dm_rdata <= rd_data;
                        end
                    end
                end
                DONE: begin
                    // Requests are deliberately not sampled here: the owner's req is still high.
                    last_dm <= (owner == OWN_DM);
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases plus randomized traffic against a word-memory model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
    localparam int TMO    = 4;
`else
    localparam bit TMO_EN = 1'b0;
    localparam int TMO    = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic        if_ack, dm_ack, mem_req, mem_we, err;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: word memory, tie-break history, expected read registers, pending requests.
    logic [31:0] mem_model [logic [29:0]];
    bit          last_dm = 1'b0;
    logic [31:0] exp_if_rdata = '0, exp_dm_rdata = '0;
    bit          if_pend = 1'b0, dm_pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (!mem_model.exists(a[31:2])) mem_model[a[31:2]] = $urandom;
        return mem_model[a[31:2]];
    endfunction

    task automatic raise_if(input logic [31:0] a);
        if_req = 1'b1; if_addr = a; if_pend = 1'b1;
    endtask

    task automatic raise_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
        dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d; dm_pend = 1'b1;
    endtask

    // One complete access: grant edge, `waits` stalled cycles, completion, ack, return to idle.
    task automatic serve(input int waits);
        bit          is_dm, we, tmo;
        logic [31:0] a, d, word_addr, rd;
        int          eff;
        is_dm     = (if_pend && dm_pend) ? !last_dm : dm_pend;
        a         = is_dm ? dm_addr : if_addr;
        we        = is_dm && dm_we;
        d         = dm_wdata;
        word_addr = {a[31:2], 2'b00};
        tmo       = TMO_EN && (waits >= TMO);
        eff       = tmo ? TMO - 1 : waits;

        tick();
        chk("grant_mem_req", mem_req, 1);
        chk("grant_mem_addr", mem_addr, word_addr);
        chk("grant_mem_we", mem_we, we);
        if (we) chk("grant_mem_wdata", mem_wdata, d);
        for (int i = 0; i < eff; i++) begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            tick();
            chk("wait_mem_req", mem_req, 1);
            chk("wait_addr_stable", mem_addr, word_addr);
            chk("wait_no_ack", {if_ack, dm_ack}, 0);
            chk("wait_err", err, 0);
        end
        rd = 32'hDEAD_BEEF;
        if (!tmo) begin
            rd        = we ? $urandom : mem_rd(a);
            mem_ready = 1'b1;
            mem_rdata = rd;
            if (we) mem_model[a[31:2]] = d;
        end
        tick();
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (!we) begin
            if (is_dm) exp_dm_rdata = rd;
            else       exp_if_rdata = rd;
        end
        chk("done_if_ack", if_ack, !is_dm);
        chk("done_dm_ack", dm_ack, is_dm);
        chk("done_mem_req", mem_req, 0);
        chk("done_if_rdata", if_rdata, exp_if_rdata);
        chk("done_dm_rdata", dm_rdata, exp_dm_rdata);
        chk("done_err", err, tmo);
        if (is_dm) begin dm_req = 1'b0; dm_pend = 1'b0; end
        else       begin if_req = 1'b0; if_pend = 1'b0; end
        last_dm = is_dm;
        tick();
        chk("idle_acks", {if_ack, dm_ack, err}, 0);
        chk("idle_mem_req", mem_req, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_outputs", {if_ack, dm_ack, mem_req, mem_we, err}, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_idle", mem_req, 0);

        // First tie after reset goes to DM, then IF, then alternation continues
        raise_if(32'h0000_0100);
        raise_dm(1'b0, 32'h0000_0200, 32'h0);
        chk("tie1_owner_is_dm", {1'b0, !last_dm}, 1);
        serve(0);
        serve(0);
        raise_if(32'h0000_0104);
        raise_dm(1'b1, 32'h0000_0204, 32'h1234_5678);
        serve(1);
        serve(0);

        // Fetch with zero wait states and a known instruction word
        mem_model[30'(32'h0000_3004 >> 2)] = 32'h3C01_0001;
        raise_if(32'h0000_3004);
        serve(0);
        chk("t1_if_rdata", if_rdata, 32'h3C01_0001);

        // Unaligned store: low bits dropped, dm_rdata untouched
        raise_dm(1'b1, 32'h0000_0013, 32'hA5A5_A5A5);
        serve(0);
        chk("t2_store_word", mem_model[30'h4], 32'hA5A5_A5A5);

        // Load with three wait states reads back the store
        raise_dm(1'b0, 32'h0000_0010, 32'h0);
        serve(3);
        chk("t4_load_data", dm_rdata, 32'hA5A5_A5A5);

        // Randomized traffic over a small address window so loads hit earlier stores
        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = $urandom_range(0, 2);
            if (sel != 1) raise_if(32'($urandom_range(0, 63)));
            if (sel != 0) raise_dm(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
            serve($urandom_range(0, 3));
            if (if_pend || dm_pend) serve($urandom_range(0, 3));
        end

        // Reset in the middle of a stalled access abandons it
        raise_if(32'h0000_0040);
        tick();
        mem_ready = 1'b0;
        tick();
        chk("t5_busy_before_rst", mem_req, 1);
        rst = 1'b0;
        #1;
        chk("t5_rst_mem_req", mem_req, 0);
        chk("t5_rst_acks", {if_ack, dm_ack, err}, 0);
        chk("t5_rst_if_rdata", if_rdata, 0);
        chk("t5_rst_dm_rdata", dm_rdata, 0);
        if_req = 1'b0; if_pend = 1'b0;
        last_dm = 1'b0; exp_if_rdata = '0; exp_dm_rdata = '0;
        tick();
        rst = 1'b1;
        tick();
        chk("t5_no_late_ack", {if_ack, dm_ack, mem_req}, 0);
        raise_if(32'h0000_0044);
        serve(1);

        // Memory stuck not-ready for a long stretch: times out only when the watchdog is built in
        raise_if(32'h0000_0048);
        serve(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
